mem_wb_stage: RTL and testbench

- MEM stage of the 64-bit in-order pipeline, fed directly by the EX/MEM pipeline register outputs.
- Contains the doubleword data memory, the branch-resolution (PCSrc) logic, and the MEM/WB pipeline register that feeds write-back.
- Loads take one cycle: read data is captured into MEM/WB at the same edge as the rest of the instruction's fields.

---
 rtl/mem_wb_stage.sv | 97 +++++++++
 tb/tb_mem_wb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage of the 64-bit in-order pipeline: doubleword data memory, branch resolution,
// and the MEM/WB pipeline register that feeds write-back.
module mem_wb_stage #(
    parameter int DEPTH    = 64,
    parameter int ADDR_LSB = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_in,
    input  logic [2:0]  m_in,
    input  logic [63:0] adder_out_in,
    input  logic [63:0] alu_result_in,
    input  logic        mux_in,
    input  logic [63:0] store_data_in,
    input  logic [4:0]  rd_in,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic [1:0]  wb_out,
    output logic [63:0] read_data_out,
    output logic [63:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        mem_fault
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int IDX_HI = ADDR_LSB + IDX_W;

    logic [63:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             aligned;
    logic             legal;
    logic             mem_read;
    logic             mem_write;

    logic [1:0]       wb_q;
    logic [63:0]      read_data_q, read_data_d;
    logic [63:0]      alu_result_q;
    logic [4:0]       rd_q;
    logic             fault_q, fault_d;

    assign mem_read  = m_in[1];
    assign mem_write = m_in[0];

    // Upper address bits only qualify the access; they never alias into the index.
    assign idx      = alu_result_in[IDX_HI-1:ADDR_LSB];
    assign in_range = (alu_result_in[63:IDX_HI] == '0);
    assign aligned  = (alu_result_in[ADDR_LSB-1:0] == '0);
    assign legal    = in_range & aligned;

    assign pcsrc         = m_in[2] & mux_in;
    assign branch_target = adder_out_in;

    // Reading mem_q before the edge gives old content on a same-index read/write.
    always_comb begin
        read_data_d = '0;
        if (mem_read && legal) begin
            read_data_d = mem_q[idx];
        end
        fault_d = fault_q
                | ((mem_read | mem_write) & ~legal)
                | (mem_read & mem_write);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write && legal) begin
            mem_q[idx] <= store_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q         <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            fault_q      <= 1'b0;
        end else begin
            wb_q         <= wb_in;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_in;
            rd_q         <= rd_in;
            fault_q      <= fault_d;
        end
    end

    assign wb_out         = wb_q;
    assign read_data_out  = read_data_q;
    assign alu_result_out = alu_result_q;
    assign rd_out         = rd_q;
    assign mem_fault      = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: reset, load/store, read-during-write,
// faults, branch resolution and MEM/WB streaming.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic [63:0] adder_out_in;
    logic [63:0] alu_result_in;
    logic        mux_in;
    logic [63:0] store_data_in;
    logic [4:0]  rd_in;
    logic        pcsrc;
    logic [63:0] branch_target;
    logic [1:0]  wb_out;
    logic [63:0] read_data_out;
    logic [63:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        mem_fault;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.DEPTH(64), .ADDR_LSB(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_in          (wb_in),
        .m_in           (m_in),
        .adder_out_in   (adder_out_in),
        .alu_result_in  (alu_result_in),
        .mux_in         (mux_in),
        .store_data_in  (store_data_in),
        .rd_in          (rd_in),
        .pcsrc          (pcsrc),
        .branch_target  (branch_target),
        .wb_out         (wb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .mem_fault      (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] wb, input logic [2:0] m, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] rd);
        wb_in         = wb;
        m_in          = m;
        alu_result_in = addr;
        store_data_in = data;
        rd_in         = rd;
        adder_out_in  = 64'h0;
        mux_in        = 1'b0;
    endtask

    initial begin
        // Reset held from time 0 with a store presented: nothing may be written.
        reset = 1'b0;
        drv(2'b11, 3'b001, 64'h08, 64'hFFFF, 5'd7);
        tick();
        tick();
        chk("rst_wb",    {62'h0, wb_out}, 64'h0);
        chk("rst_rd",    {59'h0, rd_out}, 64'h0);
        chk("rst_rdata", read_data_out, 64'h0);
        chk("rst_alu",   alu_result_out, 64'h0);
        chk("rst_fault", {63'h0, mem_fault}, 64'h0);

        reset = 1'b1;
        drv(2'b11, 3'b010, 64'h08, 64'h0, 5'd7);
        tick();
        chk("rst_store_blocked", read_data_out, 64'h0);
        chk("ld0_wb",  {62'h0, wb_out}, 64'h3);
        chk("ld0_rd",  {59'h0, rd_out}, 64'd7);
        chk("ld0_alu", alu_result_out, 64'h08);

        // Store then load.
        drv(2'b00, 3'b001, 64'h10, 64'hDEADBEEF_CAFEF00D, 5'd0);
        tick();
        chk("st_rdata_zero", read_data_out, 64'h0);
        chk("st_fault",      {63'h0, mem_fault}, 64'h0);
        drv(2'b11, 3'b010, 64'h10, 64'h0, 5'd5);
        tick();
        chk("ld_rdata", read_data_out, 64'hDEADBEEF_CAFEF00D);
        chk("ld_wb",    {62'h0, wb_out}, 64'h3);
        chk("ld_rd",    {59'h0, rd_out}, 64'd5);
        chk("ld_alu",   alu_result_out, 64'h10);
        chk("ld_fault", {63'h0, mem_fault}, 64'h0);

        // Read-during-write returns old content and flags the illegal encoding.
        drv(2'b00, 3'b001, 64'h18, 64'h1111, 5'd0);
        tick();
        drv(2'b11, 3'b011, 64'h18, 64'h2222, 5'd9);
        tick();
        chk("rdw_old",   read_data_out, 64'h1111);
        chk("rdw_fault", {63'h0, mem_fault}, 64'h1);
        drv(2'b11, 3'b010, 64'h18, 64'h0, 5'd9);
        tick();
        chk("rdw_new",          read_data_out, 64'h2222);
        chk("rdw_fault_sticky", {63'h0, mem_fault}, 64'h1);

        // Asynchronous reset mid-cycle with random inputs, then a store under reset.
        #3;
        drv(2'($urandom), 3'b001, 64'h10, {$urandom, $urandom}, 5'($urandom));
        reset = 1'b0;
        #1;
        chk("arst_wb",    {62'h0, wb_out}, 64'h0);
        chk("arst_rd",    {59'h0, rd_out}, 64'h0);
        chk("arst_rdata", read_data_out, 64'h0);
        chk("arst_alu",   alu_result_out, 64'h0);
        chk("arst_fault", {63'h0, mem_fault}, 64'h0);
        drv(2'b00, 3'b001, 64'h10, 64'h5555, 5'd0);
        tick();
        reset = 1'b1;
        drv(2'b11, 3'b010, 64'h10, 64'h0, 5'd1);
        tick();
        chk("arst_word10", read_data_out, 64'h0);
        drv(2'b11, 3'b010, 64'h18, 64'h0, 5'd1);
        tick();
        chk("arst_word18", read_data_out, 64'h0);
        chk("arst_fault2", {63'h0, mem_fault}, 64'h0);

        // Branch resolution is combinational.
        drv(2'b00, 3'b100, 64'h0, 64'h0, 5'd0);
        adder_out_in = 64'h400;
        mux_in       = 1'b1;
        #1;
        chk("br_pcsrc",  {63'h0, pcsrc}, 64'h1);
        chk("br_target", branch_target, 64'h400);
        mux_in = 1'b0;
        #1;
        chk("br_nottaken", {63'h0, pcsrc}, 64'h0);
        m_in   = 3'b000;
        mux_in = 1'b1;
        #1;
        chk("br_nobranch", {63'h0, pcsrc}, 64'h0);

        drv(2'b00, 3'b000, 64'h0, 64'h0, 5'd0);
        tick();
        chk("bub_wb",    {62'h0, wb_out}, 64'h0);
        chk("bub_rdata", read_data_out, 64'h0);
        chk("bub_fault", {63'h0, mem_fault}, 64'h0);

        // Misaligned load: word 1 holds data, but 0x0C must read 0 and fault.
        drv(2'b00, 3'b001, 64'h08, 64'h77, 5'd0);
        tick();
        chk("pre_mis_fault", {63'h0, mem_fault}, 64'h0);
        drv(2'b11, 3'b010, 64'h0C, 64'h0, 5'd2);
        tick();
        chk("mis_rdata", read_data_out, 64'h0);
        chk("mis_fault", {63'h0, mem_fault}, 64'h1);
        drv(2'b00, 3'b000, 64'h0, 64'h0, 5'd0);
        tick();
        chk("mis_fault_sticky", {63'h0, mem_fault}, 64'h1);

        // Out-of-range stores must not alias onto words 0 and 1.
        drv(2'b00, 3'b001, 64'h200, 64'h9999, 5'd0);
        tick();
        drv(2'b00, 3'b001, 64'h208, 64'h8888, 5'd0);
        tick();
        drv(2'b11, 3'b010, 64'h00, 64'h0, 5'd3);
        tick();
        chk("oor_word0", read_data_out, 64'h0);
        drv(2'b11, 3'b010, 64'h08, 64'h0, 5'd3);
        tick();
        chk("oor_word1", read_data_out, 64'h77);

        // Back-to-back stream: each output reflects the previous cycle's inputs.
        drv(2'b10, 3'b000, 64'h100, 64'h0, 5'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("stream_rd%0d", i), {59'h0, rd_out}, 64'(i));
            chk($sformatf("stream_alu%0d", i), alu_result_out, 64'(i) * 64'h100);
            drv(2'b10, 3'b000, 64'(i + 1) * 64'h100, 64'h0, 5'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
